// File: rtl/draw_scheduler.sv
// Sprite draw command queue feeding the frame draw engine; owns the double-buffer
// select bit, which flips on the first vsync after a frame's last draw completes.
module draw_scheduler #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned COORD_W = 10
) (
  input  logic               Clk,
  input  logic               Reset_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ID_W-1:0]    cmd_img_id,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic               cmd_last,
  input  logic               vsync,
  output logic               eng_start,
  output logic [ID_W-1:0]    eng_img_id,
  output logic [COORD_W-1:0] eng_imgX,
  output logic [COORD_W-1:0] eng_imgY,
  input  logic               eng_done,
  output logic               even_frame,
  output logic               swap,
  output logic               busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 1 + ID_W + 2 * COORD_W;

  typedef enum logic [1:0] {IDLE, DRAW, WAIT_VSYNC} state_t;

  state_t             state_q, state_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               full, empty, push, pop, toggle;
  logic               last_q;
  logic [ID_W-1:0]    id_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               even_q, swap_q;
  logic [EW-1:0]      head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    toggle  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (eng_done) state_d = last_q ? WAIT_VSYNC : IDLE;
      end
      WAIT_VSYNC: begin
        if (vsync) begin
          toggle  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_last, cmd_img_id, cmd_x, cmd_y};
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= 1'b0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      even_q   <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      swap_q  <= toggle;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        {last_q, id_q, x_q, y_q} <= head;
      end
      if (toggle) even_q <= ~even_q;
    end
  end

  assign cmd_ready  = !full;
  assign eng_start  = (state_q == DRAW);
  assign eng_img_id = id_q;
  assign eng_imgX   = x_q;
  assign eng_imgY   = y_q;
  assign even_frame = even_q;
  assign swap       = swap_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: latency, frame swap, full queue, vsync collision,
// commands queued during the vsync wait, and asynchronous reset mid-draw.
module tb_draw_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_N;
  logic       cmd_valid, cmd_ready, cmd_last, vsync, eng_start, eng_done;
  logic [2:0] cmd_img_id, eng_img_id;
  logic [9:0] cmd_x, cmd_y, eng_imgX, eng_imgY;
  logic       even_frame, swap, busy;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  draw_scheduler #(.DEPTH(8), .ID_W(3), .COORD_W(10)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_img_id(cmd_img_id),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_last(cmd_last), .vsync(vsync),
    .eng_start(eng_start), .eng_img_id(eng_img_id), .eng_imgX(eng_imgX),
    .eng_imgY(eng_imgY), .eng_done(eng_done), .even_frame(even_frame),
    .swap(swap), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y,
                         input logic last);
    cmd_valid  = 1'b1;
    cmd_img_id = id;
    cmd_x      = x;
    cmd_y      = y;
    cmd_last   = last;
  endtask

  initial begin
    Reset_N = 1'b0; cmd_valid = 1'b0; cmd_img_id = '0; cmd_x = '0; cmd_y = '0;
    cmd_last = 1'b0; vsync = 1'b0; eng_done = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_even", 32'(even_frame), 0);
    chk("rst_swap", 32'(swap), 0);
    chk("rst_id", 32'(eng_img_id), 0);
    Reset_N = 1'b1;
    tick();

    // Single command: accepted at E0, drawn from E1, done at E5
    set_cmd(3'd2, 10'd100, 10'd50, 1'b0);
    tick(); cmd_valid = 1'b0;
    chk("single_e0_start", 32'(eng_start), 0);
    chk("single_e0_busy", 32'(busy), 1);
    tick();
    chk("single_e1_start", 32'(eng_start), 1);
    chk("single_id", 32'(eng_img_id), 2);
    chk("single_x", 32'(eng_imgX), 100);
    chk("single_y", 32'(eng_imgY), 50);
    tick(); tick(); tick();
    chk("single_e4_start", 32'(eng_start), 1);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("single_done_start", 32'(eng_start), 0);
    chk("single_done_busy", 32'(busy), 0);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("idle_done_ignored", 32'(busy), 0);

    // Frame swap
    set_cmd(3'd5, 10'd7, 10'd9, 1'b1);
    tick(); cmd_valid = 1'b0;
    tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("swap_wait_start", 32'(eng_start), 0);
    chk("swap_wait_busy", 32'(busy), 1);
    chk("swap_wait_even", 32'(even_frame), 0);
    tick(); tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("swap_even", 32'(even_frame), 1);
    chk("swap_pulse", 32'(swap), 1);
    chk("swap_busy", 32'(busy), 0);
    tick();
    chk("swap_pulse_end", 32'(swap), 0);
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("vsync2_even", 32'(even_frame), 1);
    chk("vsync2_swap", 32'(swap), 0);

    // Full FIFO: 9 accepted while the first draw stalls
    for (int i = 0; i < 9; i++) begin
      set_cmd(3'(i), 10'(i * 10), 10'(i * 3 + 1), 1'b0);
      chk($sformatf("full_ready_%0d", i), 32'(cmd_ready), 1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_not_ready", 32'(cmd_ready), 0);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("drain_start_%0d", k), 32'(eng_start), 1);
      chk($sformatf("drain_id_%0d", k), 32'(eng_img_id), 32'(k % 8));
      chk($sformatf("drain_x_%0d", k), 32'(eng_imgX), 32'(k * 10));
      chk($sformatf("drain_y_%0d", k), 32'(eng_imgY), 32'(k * 3 + 1));
      eng_done = 1'b1; tick(); eng_done = 1'b0;
      chk($sformatf("drain_gap_%0d", k), 32'(eng_start), 0);
      tick();
    end
    chk("drain_idle_busy", 32'(busy), 0);
    chk("drain_ready", 32'(cmd_ready), 1);

    // vsync coincident with last done is missed
    set_cmd(3'd3, 10'd30, 10'd33, 1'b1);
    tick(); cmd_valid = 1'b0;
    tick();
    eng_done = 1'b1; vsync = 1'b1; tick(); eng_done = 1'b0; vsync = 1'b0;
    chk("coll_even", 32'(even_frame), 1);
    chk("coll_swap", 32'(swap), 0);
    chk("coll_busy", 32'(busy), 1);
    tick(); tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("coll_next_even", 32'(even_frame), 0);
    chk("coll_next_swap", 32'(swap), 1);
    tick();
    chk("coll_swap_end", 32'(swap), 0);

    // Commands queued during WAIT_VSYNC draw after the swap
    set_cmd(3'd1, 10'd1, 10'd1, 1'b1);
    tick(); cmd_valid = 1'b0;
    tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    set_cmd(3'd4, 10'd40, 10'd44, 1'b0);
    tick();
    set_cmd(3'd6, 10'd60, 10'd66, 1'b0);
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    chk("q_wait_start", 32'(eng_start), 0);
    chk("q_wait_busy", 32'(busy), 1);
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("q_even", 32'(even_frame), 1);
    chk("q_swap", 32'(swap), 1);
    chk("q_swap_start", 32'(eng_start), 0);
    tick();
    chk("q1_start", 32'(eng_start), 1);
    chk("q1_id", 32'(eng_img_id), 4);
    chk("q1_x", 32'(eng_imgX), 40);
    chk("q1_y", 32'(eng_imgY), 44);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("q1_gap", 32'(eng_start), 0);
    tick();
    chk("q2_start", 32'(eng_start), 1);
    chk("q2_id", 32'(eng_img_id), 6);
    chk("q2_x", 32'(eng_imgX), 60);
    chk("q2_y", 32'(eng_imgY), 66);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("q2_done_busy", 32'(busy), 0);
    chk("q_swap_stays", 32'(even_frame), 1);

    // Asynchronous reset mid-draw
    set_cmd(3'd7, 10'd70, 10'd77, 1'b0);
    tick(); cmd_valid = 1'b0;
    tick();
    chk("mid_start", 32'(eng_start), 1);
    #2 Reset_N = 1'b0;
    #1;
    chk("arst_start", 32'(eng_start), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_even", 32'(even_frame), 0);
    chk("arst_id", 32'(eng_img_id), 0);
    tick();
    Reset_N = 1'b1;
    tick(); tick();
    chk("post_rst_start", 32'(eng_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
